// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, digit width
// and the index-width helper used to size the digit counter.
package nsa_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } nsa_state_e;

    // A single-digit adder still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_add_4.sv
// add_4: one 4-bit digit adder stage with carry-in and carry-out.
module add_4
    import nsa_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               ci_i,
    output logic [DIGIT_W-1:0] s_o,
    output logic               co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT_W{1'b0}}, ci_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// Digit-serial adder: one 4-bit digit per RUN cycle, LSB first, through a
// single add_4 stage. Define NIBBLE_SERIAL_ADDER_OVF_EN to add the OV output.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DIGIT_W*NIBBLES-1:0] A,
    input  logic [DIGIT_W*NIBBLES-1:0] B,
    input  logic                       CI,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*NIBBLES-1:0] S,
    output logic                       CO
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                       OV
`endif
);

    localparam int W  = DIGIT_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    nsa_state_e         state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       s_q;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      idx_d;
    logic               carry_q;
    logic               co_q;
    logic               busy_q;
    logic               done_q;

    logic [DIGIT_W-1:0] dig_a;
    logic [DIGIT_W-1:0] dig_b;
    logic [DIGIT_W-1:0] dig_s;
    logic               dig_co;

    assign dig_a = a_q[idx_q*DIGIT_W +: DIGIT_W];
    assign dig_b = b_q[idx_q*DIGIT_W +: DIGIT_W];
    assign idx_d = idx_q + 1'b1;

    add_4 u_add (
        .a_i  (dig_a),
        .b_i  (dig_b),
        .ci_i (carry_q),
        .s_o  (dig_s),
        .co_o (dig_co)
    );

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ov_q;
    logic ov_d;

    // Carry into the top bit is recovered from the stage's own bit-3 sum.
    assign ov_d = dig_a[DIGIT_W-1] ^ dig_b[DIGIT_W-1] ^ dig_s[DIGIT_W-1] ^ dig_co;
    assign OV   = ov_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ov_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts start directly so operations can run back to back.
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= CI;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    s_q[idx_q*DIGIT_W +: DIGIT_W] <= dig_s;
                    carry_q                       <= dig_co;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        co_q    <= dig_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        ov_q    <= ov_d;
`endif
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign CO   = co_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4); OV checks are compiled in
// when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        CI = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        CO;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        OV;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .CI    (CI),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .CO    (CO)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .OV    (OV)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one addition from the current cycle and follow it to its done cycle.
    task automatic do_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] es, input logic eco,
                          input logic eov, input logic prev_co);
        A = a; B = b; CI = ci; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("%s_busy_c%0d", tag, c), busy, 1);
            check($sformatf("%s_done_c%0d", tag, c), done, 0);
            check($sformatf("%s_co_hold_c%0d", tag, c), CO, prev_co);
            step();
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_S"}, S, es);
        check({tag, "_CO"}, CO, eco);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check({tag, "_OV"}, OV, eov);
`else
        if (eov) begin end
`endif
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_S", S, 16'h0000);
        check("rst_CO", CO, 0);

        // Basic add; then done must drop and the FSM must idle.
        do_add("add_3_4", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);
        step();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_S_hold", S, 16'h0007);

        // Full ripple through all digits.
        do_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        check("ripple_CO_hold", CO, 1);

        // Carry-in used; CO from previous op must hold through RUN.
        do_add("cin", 16'h2F09, 16'h1109, 1'b1, 16'h4013, 1'b0, 1'b0, 1'b1);
        // Start in the DONE cycle: no idle gap before busy.
        do_add("b2b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // start re-asserted mid-run with different operands is ignored.
        A = 16'h1234; B = 16'h1111; CI = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        A = 16'hFFFF; B = 16'hFFFF; CI = 1'b1; start = 1'b1;
        check("ign_busy_c2", busy, 1);
        step();
        start = 1'b0;
        check("ign_busy_c3", busy, 1);
        check("ign_done_c3", done, 0);
        step();
        check("ign_busy_c4", busy, 1);
        step();
        check("ign_done", done, 1);
        check("ign_S", S, 16'h2345);
        check("ign_CO", CO, 0);
        step();
        check("ign_after_done", done, 0);
        check("ign_after_busy", busy, 0);

        // Leave S and CO non-zero so reset clearing is observable.
        do_add("pre_rst", 16'hFFFF, 16'h0002, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        step();

        // Reset in cycle 3 of RUN abandons the operation.
        A = 16'h0F0F; B = 16'h0101; CI = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstrun_busy", busy, 0);
        check("rstrun_done", done, 0);
        check("rstrun_S", S, 16'h0000);
        check("rstrun_CO", CO, 0);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("rstrun_nodone_%0d", c), done, 0);
            step();
        end

        // Recovery after reset.
        do_add("post_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        do_add("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_add("no_ovf", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
